// File: rtl/coin_event_scheduler_if.sv
// coin_event_scheduler_if: coin-slot inputs, FSM pulse outputs and status of the coin scheduler
interface coin_event_scheduler_if #(parameter int CNT_W = 3);
  logic coin5_in;
  logic coin10_in;
  logic busy;
  logic flush;
  logic clr_ovf;
  logic in_5;
  logic in_10;
  logic [CNT_W-1:0] pend5;
  logic [CNT_W-1:0] pend10;
  logic ovf;
  modport master (
    output coin5_in, coin10_in, busy, flush, clr_ovf,
    input  in_5, in_10, pend5, pend10, ovf
  );
  modport slave (
    input  coin5_in, coin10_in, busy, flush, clr_ovf,
    output in_5, in_10, pend5, pend10, ovf
  );
endinterface

// File: rtl/coin_event_scheduler.sv
// coin_event_scheduler: queues coin-slot edges and issues spaced, round-robin in_5/in_10 pulses
module coin_event_scheduler #(
  parameter int CNT_W = 3,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst_n,
  coin_event_scheduler_if.slave bus
);
  typedef enum logic {S_IDLE, S_GAP} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] p5, p10, p5_n, p10_n;
  logic [3:0] gap, gap_n;
  logic c5_q, c10_q, last, last_n, ovf, ovf_n, in5, in10;
  logic rise5, rise10, dec, g5, g10, drop5, drop10;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      p5 <= '0;
      p10 <= '0;
      gap <= '0;
      c5_q <= 1'b1;
      c10_q <= 1'b1;
      last <= 1'b0;
      ovf <= 1'b0;
      in5 <= 1'b0;
      in10 <= 1'b0;
    end else begin
      state <= state_n;
      p5 <= p5_n;
      p10 <= p10_n;
      gap <= gap_n;
      c5_q <= bus.coin5_in;
      c10_q <= bus.coin10_in;
      last <= last_n;
      ovf <= ovf_n;
      in5 <= g5;
      in10 <= g10;
    end
  // last=1 means slot 5 was granted last; contention goes to the other slot
  always_comb begin
    rise5 = bus.coin5_in & ~c5_q;
    rise10 = bus.coin10_in & ~c10_q;
    dec = state == S_IDLE && !bus.busy && !bus.flush && (p5 != '0 || p10 != '0);
    g5 = dec && p5 != '0 && (p10 == '0 || !last);
    g10 = dec && !g5;
    drop5 = !bus.flush && rise5 && &p5 && !g5;
    drop10 = !bus.flush && rise10 && &p10 && !g10;
    p5_n = bus.flush ? '0 : drop5 ? p5 : p5 + CNT_W'(rise5) - CNT_W'(g5);
    p10_n = bus.flush ? '0 : drop10 ? p10 : p10 + CNT_W'(rise10) - CNT_W'(g10);
    ovf_n = drop5 || drop10 || (ovf && !bus.clr_ovf);
    last_n = g5 ? 1'b1 : g10 ? 1'b0 : last;
    gap_n = dec ? 4'(GAP) : state == S_GAP ? gap - 4'd1 : gap;
    state_n = dec ? S_GAP : (state == S_GAP && gap == 4'd1) ? S_IDLE : state;
  end
  assign bus.in_5 = in5;
  assign bus.in_10 = in10;
  assign bus.pend5 = p5;
  assign bus.pend10 = p10;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_coin_event_scheduler.sv
// tb_coin_event_scheduler: directed plan plus random traffic against a cycle-count reference model
module tb_coin_event_scheduler;
  localparam int CNT_W = 3;
  localparam int GAP = 1;
  localparam int MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  coin_event_scheduler_if #(.CNT_W(CNT_W)) bus ();
  coin_event_scheduler #(.CNT_W(CNT_W), .GAP(GAP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int m_p5, m_p10, m_last, m_next, cyc;
  bit m_ovf, m_i5, m_i10, prev5, prev10;
  int vend, dispenses;
  bit vend_on = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_p5 = 0;
    m_p10 = 0;
    m_last = 10;
    m_next = 0;
    cyc = 0;
    m_ovf = 1'b0;
    m_i5 = 1'b0;
    m_i10 = 1'b0;
    prev5 = 1'b1;
    prev10 = 1'b1;
  endtask
  // a decision may happen once the cycle count reaches the last grant time plus GAP+1
  task automatic model_step();
    bit r5, r10, dropped;
    int g;
    r5 = bus.coin5_in && !prev5;
    r10 = bus.coin10_in && !prev10;
    prev5 = bus.coin5_in;
    prev10 = bus.coin10_in;
    g = 0;
    dropped = 1'b0;
    if (cyc >= m_next && !bus.busy && !bus.flush && (m_p5 > 0 || m_p10 > 0)) begin
      g = (m_p5 > 0 && (m_p10 == 0 || m_last == 10)) ? 5 : 10;
      m_last = g;
      m_next = cyc + GAP + 1;
    end
    m_i5 = (g == 5);
    m_i10 = (g == 10);
    if (bus.flush) begin
      m_p5 = 0;
      m_p10 = 0;
    end else begin
      if (g == 5) m_p5--;
      if (g == 10) m_p10--;
      if (r5) begin
        if (m_p5 < MAX) m_p5++;
        else dropped = 1'b1;
      end
      if (r10) begin
        if (m_p10 < MAX) m_p10++;
        else dropped = 1'b1;
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (bus.clr_ovf) m_ovf = 1'b0;
    cyc++;
  endtask
  task automatic tick();
    bit d5, d10;
    d5 = bus.in_5;
    d10 = bus.in_10;
    @(posedge clk);
    model_step();
    #1;
    if (vend_on) begin
      if (vend == 15) vend = 0;
      else begin
        vend += (d5 ? 5 : 0) + (d10 ? 10 : 0);
        if (vend >= 15) begin
          vend = 15;
          dispenses++;
        end
      end
      bus.busy = (vend == 15);
    end
    chk("in_5", 32'(bus.in_5), 32'(m_i5));
    chk("in_10", 32'(bus.in_10), 32'(m_i10));
    chk("pend5", 32'(bus.pend5), m_p5);
    chk("pend10", 32'(bus.pend10), m_p10);
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  endtask
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_in_5", 32'(bus.in_5), 0);
    chk("rst_in_10", 32'(bus.in_10), 0);
    chk("rst_pend5", 32'(bus.pend5), 0);
    chk("rst_pend10", 32'(bus.pend10), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic edge5();
    bus.coin5_in = 1'b0;
    tick();
    bus.coin5_in = 1'b1;
    tick();
  endtask
  task automatic edge10();
    bus.coin10_in = 1'b0;
    tick();
    bus.coin10_in = 1'b1;
    tick();
  endtask
  initial begin
    bus.coin5_in = 1'b1;
    bus.coin10_in = 1'b0;
    bus.busy = 1'b0;
    bus.flush = 1'b0;
    bus.clr_ovf = 1'b0;
    model_reset();
    #12;
    chk("por_pend5", 32'(bus.pend5), 0);
    chk("por_in_5", 32'(bus.in_5), 0);
    #10;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("t1_held_pend5", 32'(bus.pend5), 0);
    bus.coin5_in = 1'b0;
    tick();
    bus.coin5_in = 1'b1;
    tick();
    chk("t1_pend5_one", 32'(bus.pend5), 1);
    tick();
    chk("t1_pulse", 32'(bus.in_5), 1);
    chk("t1_pend5_zero", 32'(bus.pend5), 0);
    tick();
    chk("t1_pulse_end", 32'(bus.in_5), 0);
    do_reset();
    bus.coin5_in = 1'b0;
    bus.coin10_in = 1'b0;
    tick();
    bus.coin5_in = 1'b1;
    bus.coin10_in = 1'b1;
    tick();
    chk("t2_pend5", 32'(bus.pend5), 1);
    chk("t2_pend10", 32'(bus.pend10), 1);
    tick();
    chk("t2_first5", 32'(bus.in_5), 1);
    tick();
    tick();
    chk("t2_then10", 32'(bus.in_10), 1);
    chk("t2_ovf", 32'(bus.ovf), 0);
    repeat (3) tick();
    bus.busy = 1'b1;
    edge10();
    edge10();
    edge10();
    repeat (4) tick();
    chk("t3_pend10", 32'(bus.pend10), 3);
    bus.busy = 1'b0;
    repeat (8) tick();
    chk("t3_drained", 32'(bus.pend10), 0);
    bus.busy = 1'b1;
    repeat (8) edge5();
    chk("t4_pend5_sat", 32'(bus.pend5), MAX);
    chk("t4_ovf_set", 32'(bus.ovf), 1);
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(bus.ovf), 0);
    chk("t4_pend5_kept", 32'(bus.pend5), MAX);
    bus.busy = 1'b0;
    repeat (20) tick();
    bus.busy = 1'b1;
    edge5();
    edge5();
    edge10();
    bus.coin5_in = 1'b0;
    tick();
    bus.coin5_in = 1'b1;
    bus.flush = 1'b1;
    bus.busy = 1'b0;
    tick();
    bus.flush = 1'b0;
    chk("t5_pend5", 32'(bus.pend5), 0);
    chk("t5_pend10", 32'(bus.pend10), 0);
    chk("t5_ovf", 32'(bus.ovf), 0);
    repeat (3) tick();
    do_reset();
    vend = 0;
    dispenses = 0;
    vend_on = 1'b1;
    bus.coin5_in = 1'b0;
    bus.coin10_in = 1'b0;
    tick();
    bus.coin5_in = 1'b1;
    tick();
    bus.coin10_in = 1'b1;
    tick();
    bus.coin5_in = 1'b0;
    tick();
    bus.coin5_in = 1'b1;
    repeat (12) tick();
    chk("t6_dispenses", dispenses, 1);
    chk("t6_vend_after", vend, 5);
    vend_on = 1'b0;
    bus.busy = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      if ($urandom_range(2) == 0) bus.coin5_in = ~bus.coin5_in;
      if ($urandom_range(2) == 0) bus.coin10_in = ~bus.coin10_in;
      bus.busy = ((i / 60) % 2 == 1) ? ($urandom_range(9) != 0) : ($urandom_range(3) == 0);
      bus.flush = ($urandom_range(49) == 0);
      bus.clr_ovf = ($urandom_range(24) == 0);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
